pc_dispatch_queue: RTL
======================

# pc_dispatch_queue

Work-dispatch responder on the processor's new-PC handshake. It buffers program start addresses that arrive as queue writes, then hands them out one at a time. A processor raises `request_new_pc` after executing END. This block answers with a one-cycle `set_pc` pulse carrying `new_pc`, taken from the head of an internal FIFO.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `QUEUE_ID`, 4'd1: `queue_number` value this block accepts; writes with any other value are ignored.
- `BOOT_PC`, 16'd0: boot entry, used only when `PC_DISPATCH_BOOT_EN` is defined.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `queue_wen` in 1: queue write strobe.
- `queue_number` in 4: target queue of the write.
- `queue_wval` in 32: write data; bits [15:0] are the PC, bits [31:16] are ignored.
- `request_new_pc` in 1: processor is idle and wants a PC.
- `set_pc` out 1: registered one-cycle grant pulse.
- `new_pc` out 16: registered PC; valid while `set_pc` is 1.
- `count` out log2(DEPTH)+1: current number of FIFO entries.
- `empty` out 1: `count` == 0.
- `full` out 1: `count` == DEPTH.
- `overflow` out 1: sticky flag for a dropped write.

## Operation
- Enqueue condition: `queue_wen` && `queue_number` == QUEUE_ID.
  - The entry `queue_wval[15:0]` is written at the tail on the clock edge.
- Issue condition: `request_new_pc` && !`empty` && !`set_pc`.
  - On that edge: `set_pc` <= 1, `new_pc` <= head, head pointer advances, `count` decrements.
  - Otherwise `set_pc` <= 0 and `new_pc` holds its last value.
- The `!set_pc` term blocks a double grant. The processor drops `request_new_pc` only on the edge where it samples `set_pc` && `request_new_pc`, so the request is still high during the grant cycle.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- `count` changes by (enqueue accepted) minus (issue).
- Full FIFO:
  - Enqueue with no issue in the same cycle: the write is dropped, the FIFO is unchanged, `overflow` <= 1.
  - Enqueue with an issue in the same cycle: the write is accepted, `count` stays at DEPTH.
- Empty FIFO: no issue occurs; a request stays pending indefinitely.
- No bypass: an entry written on edge N can be issued no earlier than edge N+1.
- `overflow` is cleared only by reset.
- Reset, including mid-handshake: pointers 0, `count` 0 (see Configuration), `set_pc` 0, `new_pc` 0, `overflow` 0.
  - A grant in flight is lost. The processor's request remains high, and the grant is reissued after reset if the FIFO is non-empty.

## Timing
- Request to grant: `request_new_pc` sampled high at edge N with a non-empty FIFO gives `set_pc`=1 during cycle N..N+1.
  - The processor loads the PC at edge N+1.
  - `set_pc` is 0 after edge N+1.
- Minimum spacing between grants: 2 cycles.
- Write to grant: a write at edge N with a pending request gives `set_pc` high after edge N+1.
- `empty`, `full` and `count` are registered and reflect the state after the last edge.
- No combinational path from any input to any output.

## Configuration
- `PC_DISPATCH_BOOT_EN` defined:
  - Reset loads entry 0 with BOOT_PC, `count` = 1, tail pointer = 1, `empty` = 0.
  - The first request after reset is granted BOOT_PC.
- Not defined:
  - Reset leaves the FIFO empty, `count` = 0.
  - Processors stay idle until the first accepted write.

## Test plan
- Reset without the macro, `request_new_pc`=1, no writes for 10 cycles:
  - `set_pc` stays 0, `count`=0, `empty`=1.
- Writes of 0x0010, 0x0020, 0x0030 to QUEUE_ID, then a request held high, dropped on the edge after each grant:
  - Three grants in FIFO order, 0x0010, 0x0020, 0x0030, each pulse 1 cycle, spaced at least 2 cycles apart.
  - `count` ends at 0.
- Write with `queue_number`=4 and `queue_wval`=0x1234:
  - Ignored; `count` unchanged.
- DEPTH=8: 9 writes with no requests:
  - `count`=8, `full`=1, `overflow`=1.
  - The first 8 values are issued in order; the ninth is never issued.
- With `full`=1, a write and an issue on the same edge:
  - Write accepted, `count` stays 8, `overflow` unchanged.
- With the macro and BOOT_PC=0x0100: deassert `rst_n` asynchronously mid-pulse while `set_pc` is high, then release with a request pending:
  - `set_pc` goes to 0 immediately.
  - After release, `set_pc` goes to 1 with `new_pc`=0x0100 one edge after the request is sampled.

Source files
------------

// File: rtl/pc_dispatch_queue.sv
// pc_dispatch_queue: buffers program start addresses written to one queue
// number and hands them out, one per request, on the new-PC handshake.
// Optional feature macro: PC_DISPATCH_BOOT_EN (reset preloads BOOT_PC as
// the first FIFO entry).
module pc_dispatch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [3:0]  QUEUE_ID = 4'd1,
    parameter logic [15:0] BOOT_PC  = 16'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     queue_wen,
    input  logic [3:0]               queue_number,
    input  logic [31:0]              queue_wval,
    input  logic                     request_new_pc,
    output logic                     set_pc,
    output logic [15:0]              new_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef PC_DISPATCH_BOOT_EN
    localparam logic [AW-1:0] RST_WR_PTR = AW'(1);
    localparam logic [CW-1:0] RST_COUNT  = CW'(1);
`else
    localparam logic [AW-1:0] RST_WR_PTR = '0;
    localparam logic [CW-1:0] RST_COUNT  = '0;
`endif

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          enq;
    logic          issue;
    logic          accept;
    logic          unused_wval_hi;

    // Upper half of the write word carries no PC information.
    assign unused_wval_hi = ^queue_wval[31:16];

    // Flags come straight from the registered count, so no input reaches them.
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A grant is withheld while one is already on the wire; a write into a
    // full FIFO only fits if an entry leaves on the same edge.
    assign enq    = queue_wen && (queue_number == QUEUE_ID);
    assign issue  = request_new_pc && !empty && !set_pc;
    assign accept = enq && (!full || issue);

`ifdef PC_DISPATCH_BOOT_EN
    // Storage; reset seeds entry 0 with the boot address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == 0) ? BOOT_PC : 16'd0;
            end
        end else if (accept) begin
            mem[wr_ptr] <= queue_wval[15:0];
        end
    end
`else
    // Storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= queue_wval[15:0];
        end
    end
`endif

    // Pointers, occupancy, grant pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= RST_WR_PTR;
            rd_ptr   <= '0;
            count    <= RST_COUNT;
            set_pc   <= 1'b0;
            new_pc   <= 16'd0;
            overflow <= 1'b0;
        end else begin
            set_pc <= issue;
            if (issue) begin
                new_pc <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (enq && !accept) begin
                overflow <= 1'b1;
            end
            case ({accept, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
